mdsr_unit: RTL

MDSR_UNIT -- requirements
Module: mdsr_unit

---
 rtl/mdsr_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mdsr_unit.sv
// mdsr_unit: sequential signed multiply / divide / square-root unit.
// One result bit per cycle; operands are loaded one at a time over Data.
module mdsr_unit #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       load,
  input  logic [1:0]                 op,
  input  logic [WORD_LENGTH-1:0]     Data,
  output logic                       x,
  output logic                       y,
  output logic                       busy,
  output logic                       ready,
  output logic [2*WORD_LENGTH-1:0]   Result,
  output logic                       error
);

  localparam int N  = WORD_LENGTH;
  localparam int CW = $clog2(N);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_SQRT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WAIT_X, WAIT_Y, CALC, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [N-1:0]    opa_q, opa_d;
  logic [2*N-1:0]  opb_q, opb_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            xneg_q, xneg_d;
  logic            neg_q, neg_d;
  logic            xmin_q, xmin_d;
  logic            ovf_q, ovf_d;
  logic [2*N-1:0]  res_q, res_d;
  logic            err_q, err_d;

  logic [N-1:0]    mag;
  logic            dneg, dzero, dones, dmin;

  logic [2*N-1:0]  mul_acc;
  logic [N:0]      div_r, div_rn;
  logic            div_ge;
  logic [N+1:0]    sq_r, sq_t, sq_rn;
  logic            sq_ge;

  logic [2*N-1:0]  step_acc;
  logic [N-1:0]    step_opa;
  logic [2*N-1:0]  step_opb;
  logic [CW-1:0]   last_cnt;
  logic [N-1:0]    quo, rem;
  logic [2*N-1:0]  fin_res;
  logic            fin_err;

  assign dneg  = Data[N-1];
  assign mag   = dneg ? (~Data + 1'b1) : Data;
  assign dzero = (Data == '0);
  assign dones = &Data;
  assign dmin  = (Data == {1'b1, {(N-1){1'b0}}});

  // One iteration of each algorithm on the operand magnitudes.
  always_comb begin
    mul_acc = opa_q[0] ? (acc_q + opb_q) : acc_q;
    div_r   = {acc_q[2*N-1:N], opa_q[N-1]};
    div_ge  = (div_r >= {1'b0, opb_q[N-1:0]});
    div_rn  = div_ge ? (div_r - {1'b0, opb_q[N-1:0]}) : div_r;
    sq_r    = {acc_q[2*N-1:N], opa_q[N-1:N-2]};
    sq_t    = {acc_q[N-1:0], 2'b01};
    sq_ge   = (sq_r >= sq_t);
    sq_rn   = sq_ge ? (sq_r - sq_t) : sq_r;
    step_acc = acc_q;
    step_opa = opa_q;
    step_opb = opb_q;
    last_cnt = CW'(N - 1);
    unique case (1'b1)
      (op_q == OP_MUL): begin
        step_acc = mul_acc;
        step_opa = {1'b0, opa_q[N-1:1]};
        step_opb = {opb_q[2*N-2:0], 1'b0};
      end
      (op_q == OP_DIV): begin
        step_acc = {div_rn[N-1:0], acc_q[N-2:0], div_ge};
        step_opa = {opa_q[N-2:0], 1'b0};
      end
      (op_q == OP_SQRT): begin
        step_acc = {sq_rn[N-1:0], acc_q[N-2:0], sq_ge};
        step_opa = {opa_q[N-3:0], 2'b00};
        last_cnt = CW'(N/2 - 1);
      end
      default: ;
    endcase
  end

  // Sign fix-up applied to the final iteration's value.
  always_comb begin
    quo = neg_q  ? (~step_acc[N-1:0] + 1'b1) : step_acc[N-1:0];
    rem = xneg_q ? (~step_acc[2*N-1:N] + 1'b1) : step_acc[2*N-1:N];
    fin_res = step_acc;
    fin_err = 1'b0;
    unique case (1'b1)
      (op_q == OP_MUL): fin_res = neg_q ? (~step_acc + 1'b1) : step_acc;
      (op_q == OP_DIV): begin
        fin_res = {rem, quo};
        fin_err = ovf_q;
      end
      default: ;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    xneg_d  = xneg_q;
    neg_d   = neg_q;
    xmin_d  = xmin_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          state_d = WAIT_X;
        end
      end
      WAIT_X: begin
        if (load) begin
          opa_d  = mag;
          xneg_d = dneg;
          xmin_d = dmin;
          acc_d  = '0;
          cnt_d  = '0;
          if (op_q == 2'b11 || (op_q == OP_SQRT && dneg)) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else if (op_q == OP_SQRT) begin
            neg_d   = 1'b0;
            state_d = CALC;
          end else begin
            state_d = WAIT_Y;
          end
        end
      end
      WAIT_Y: begin
        if (load) begin
          opb_d = {{N{1'b0}}, mag};
          neg_d = xneg_q ^ dneg;
          ovf_d = (op_q == OP_DIV) && xmin_q && dones;
          if (op_q == OP_DIV && dzero) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        opa_d = step_opa;
        opb_d = step_opb;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == last_cnt) begin
          res_d   = fin_res;
          err_d   = fin_err;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      xneg_q  <= 1'b0;
      neg_q   <= 1'b0;
      xmin_q  <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      xneg_q  <= xneg_d;
      neg_q   <= neg_d;
      xmin_q  <= xmin_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign x      = (state_q == WAIT_X);
  assign y      = (state_q == WAIT_Y);
  assign busy   = (state_q != IDLE);
  assign ready  = (state_q == DONE);
  assign Result = res_q;
  assign error  = err_q;

endmodule
